sram1r1w_param: RTL and testbench

SRAM1R1W_PARAM -- requirements
Module: sram1r1w_param

---
 rtl/sram1r1w_param.sv | 192 +++++++++++++++++++
 tb/tb_sram1r1w_param.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram1r1w_param.sv
// -----------------------------------------------------------------------------
// sram1r1w_param
// One-read / one-write synchronous SRAM with per-lane write mask, optional
// output register stage, optional write-to-read forwarding and a post-reset
// hardware clear sequence that zeroes every word before the array goes live.
//
// Parameters
//   DATA_W  : word width in bits
//   ADDR_W  : address width, DEPTH = 2**ADDR_W words
//   MASK_G  : bits per write-mask lane, NM = DATA_W/MASK_G lanes
//   OUT_REG : 0 -> read latency 1, 1 -> read latency 2
//   BYPASS  : 1 -> same-cycle same-address write data forwarded to the read
//
// Ports
//   CE   in  : clock, everything changes on its rising edge
//   RST  in  : asynchronous active-high reset
//   CSB1 in  : read select (active-low)
//   A1   in  : read address
//   O1   out : read data (held between reads)
//   V1   out : one-cycle pulse when O1 carries new read data
//   CSB2 in  : write select (active-low)
//   WEB2 in  : write enable (active-low)
//   A2   in  : write address
//   I2   in  : write data
//   WM2  in  : lane write mask (active-high), bit k covers I2[k*MASK_G +: MASK_G]
//   BUSY out : high while the clear sequence runs
// -----------------------------------------------------------------------------
module sram1r1w_param #(
   parameter int DATA_W  = 72,
   parameter int ADDR_W  = 8,
   parameter int MASK_G  = 8,
   parameter int OUT_REG = 0,
   parameter int BYPASS  = 1
) (
   input  logic                       CE,
   input  logic                       RST,
   input  logic                       CSB1,
   input  logic [ADDR_W-1:0]          A1,
   output logic [DATA_W-1:0]          O1,
   output logic                       V1,
   input  logic                       CSB2,
   input  logic                       WEB2,
   input  logic [ADDR_W-1:0]          A2,
   input  logic [DATA_W-1:0]          I2,
   input  logic [DATA_W/MASK_G-1:0]   WM2,
   output logic                       BUSY
);

   localparam int NM    = DATA_W / MASK_G;
   localparam int DEPTH = 1 << ADDR_W;

   // Illegal parameter combinations stop elaboration.
   generate
      if ((DATA_W % MASK_G) != 0) begin : g_bad_mask
         $error("sram1r1w_param: DATA_W must be a multiple of MASK_G");
      end
      if ((OUT_REG != 0) && (OUT_REG != 1)) begin : g_bad_outreg
         $error("sram1r1w_param: OUT_REG must be 0 or 1");
      end
      if ((BYPASS != 0) && (BYPASS != 1)) begin : g_bad_bypass
         $error("sram1r1w_param: BYPASS must be 0 or 1");
      end
   endgenerate

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_cnt;

   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   r_mem_q;
   logic [NM-1:0]       r_fwd_mask;
   logic [DATA_W-1:0]   r_fwd_data;
   logic                r_v0;

   logic                w_rd_en;
   logic                w_wr_en;
   logic                w_clr_en;
   logic                w_collide;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic [DATA_W-1:0]   w_mem_din;
   logic [NM-1:0]       w_lane_we;
   logic [DATA_W-1:0]   w_merged;

   // ---------------------------------------------------------------------------
   // Clear / ready FSM. The counter walks 0..DEPTH-1 once; the edge that clears
   // the last word (counter all ones) hands over to READY.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CE or posedge RST) begin
      if (RST) begin
         r_state <= S_CLEAR;
         r_cnt   <= '0;
      end else if (r_state == S_CLEAR) begin
         r_cnt <= r_cnt + 1'b1;
         if (&r_cnt) begin
            r_state <= S_READY;
         end
      end
   end

   assign BUSY = (r_state == S_CLEAR);

   // User traffic only counts once the array has been cleared.
   assign w_rd_en   = (r_state == S_READY) && !CSB1;
   assign w_wr_en   = (r_state == S_READY) && !CSB2 && !WEB2;
   // While RST is high the FSM sits at CLEAR/0, so this can only rewrite word 0
   // with zero on a clock edge, which the following clear pass does anyway.
   assign w_clr_en  = (r_state == S_CLEAR);
   assign w_collide = w_rd_en && w_wr_en && (A1 == A2);

   // The clear sequence shares the single write port with user writes.
   assign w_mem_addr = w_clr_en ? r_cnt : A2;
   assign w_mem_din  = w_clr_en ? '0 : I2;

   generate
      for (genvar gi = 0; gi < NM; gi++) begin : g_lane_we
         assign w_lane_we[gi] = w_clr_en | (w_wr_en & WM2[gi]);
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Storage: byte-enable style write, no reset on the array itself.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CE) begin
      for (int k = 0; k < NM; k++) begin
         if (w_lane_we[k]) begin
            r_mem[w_mem_addr][k*MASK_G +: MASK_G] <= w_mem_din[k*MASK_G +: MASK_G];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read stage 1: registered array read (returns the pre-write word on a
   // collision) plus the lanes to be overridden by forwarded write data. All of
   // these only load on an accepted read, so the merged word holds otherwise.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CE or posedge RST) begin
      if (RST) begin
         r_mem_q    <= '0;
         r_fwd_mask <= '0;
         r_fwd_data <= '0;
         r_v0       <= 1'b0;
      end else begin
         r_v0 <= w_rd_en;
         if (w_rd_en) begin
            r_mem_q    <= r_mem[A1];
            r_fwd_mask <= (BYPASS != 0 && w_collide) ? WM2 : '0;
            r_fwd_data <= I2;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NM; gi++) begin : g_merge
         assign w_merged[gi*MASK_G +: MASK_G] = r_fwd_mask[gi] ?
                                                 r_fwd_data[gi*MASK_G +: MASK_G] :
                                                 r_mem_q[gi*MASK_G +: MASK_G];
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Optional output register stage.
   // ---------------------------------------------------------------------------
   generate
      if (OUT_REG == 1) begin : g_out_reg
         logic [DATA_W-1:0] r_o1;
         logic              r_v1;

         always_ff @(posedge CE or posedge RST) begin
            if (RST) begin
               r_o1 <= '0;
               r_v1 <= 1'b0;
            end else begin
               r_v1 <= r_v0;
               if (r_v0) begin
                  r_o1 <= w_merged;
               end
            end
         end

         assign O1 = r_o1;
         assign V1 = r_v1;
      end else begin : g_no_out_reg
         assign O1 = w_merged;
         assign V1 = r_v0;
      end
   endgenerate

endmodule

// File: tb/tb_sram1r1w_param.sv
// -----------------------------------------------------------------------------
// tb_sram1r1w_param
// Two instances share one stimulus stream: instance A uses the defaults
// (latency 1, forwarding on), instance B uses OUT_REG=1 and BYPASS=0
// (latency 2, old data on collision). A word-level array model predicts every
// read result, and every cycle both instances' O1/V1/BUSY are compared.
// -----------------------------------------------------------------------------
module tb_sram1r1w_param;

   localparam int DW    = 72;
   localparam int AW    = 8;
   localparam int MG    = 8;
   localparam int NM    = DW / MG;
   localparam int DEPTH = 1 << AW;

   logic          CE   = 1'b0;
   logic          RST  = 1'b1;
   logic          CSB1 = 1'b1;
   logic          CSB2 = 1'b1;
   logic          WEB2 = 1'b1;
   logic [AW-1:0] A1   = '0;
   logic [AW-1:0] A2   = '0;
   logic [DW-1:0] I2   = '0;
   logic [NM-1:0] WM2  = '0;

   logic [DW-1:0] o1_a, o1_b;
   logic          v1_a, v1_b;
   logic          busy_a, busy_b;

   sram1r1w_param #(.DATA_W(DW), .ADDR_W(AW), .MASK_G(MG), .OUT_REG(0), .BYPASS(1)) dut_a (
      .CE(CE), .RST(RST), .CSB1(CSB1), .A1(A1), .O1(o1_a), .V1(v1_a),
      .CSB2(CSB2), .WEB2(WEB2), .A2(A2), .I2(I2), .WM2(WM2), .BUSY(busy_a)
   );

   sram1r1w_param #(.DATA_W(DW), .ADDR_W(AW), .MASK_G(MG), .OUT_REG(1), .BYPASS(0)) dut_b (
      .CE(CE), .RST(RST), .CSB1(CSB1), .A1(A1), .O1(o1_b), .V1(v1_b),
      .CSB2(CSB2), .WEB2(WEB2), .A2(A2), .I2(I2), .WM2(WM2), .BUSY(busy_b)
   );

   always #5 CE = ~CE;

   // ---------------- reference model ----------------
   typedef struct {
      int            due;
      logic [DW-1:0] d;
   } pend_t;

   logic [DW-1:0] m_mem [DEPTH];
   int            m_clr;
   bit            m_ready;
   pend_t         q_a[$];
   pend_t         q_b[$];
   logic [DW-1:0] eo_a, eo_b;
   int            edge_no;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check_outs();
      bit    ev_a, ev_b;
      pend_t p;
      ev_a = 1'b0;
      ev_b = 1'b0;
      if (q_a.size() > 0 && q_a[0].due == edge_no) begin
         p = q_a.pop_front();
         ev_a = 1'b1;
         eo_a = p.d;
      end
      if (q_b.size() > 0 && q_b[0].due == edge_no) begin
         p = q_b.pop_front();
         ev_b = 1'b1;
         eo_b = p.d;
      end
      chk("A.V1",   DW'(v1_a),   DW'(ev_a));
      chk("A.O1",   o1_a,        eo_a);
      chk("A.BUSY", DW'(busy_a), DW'(!m_ready));
      chk("B.V1",   DW'(v1_b),   DW'(ev_b));
      chk("B.O1",   o1_b,        eo_b);
      chk("B.BUSY", DW'(busy_b), DW'(!m_ready));
   endtask

   // Advance one clock with the currently driven inputs, update the model and
   // compare both instances 1 time unit after the edge.
   task automatic step();
      logic [DW-1:0] rd_fwd, rd_old;
      bit            rd_ok, wr_ok;
      pend_t         p;
      rd_ok = m_ready && (CSB1 == 1'b0);
      wr_ok = m_ready && (CSB2 == 1'b0) && (WEB2 == 1'b0);
      if (rd_ok) begin
         rd_old = m_mem[A1];
         rd_fwd = rd_old;
         if (wr_ok && A1 == A2) begin
            for (int k = 0; k < NM; k++) begin
               if (WM2[k]) rd_fwd[k*MG +: MG] = I2[k*MG +: MG];
            end
         end
         p.due = edge_no + 1; p.d = rd_fwd; q_a.push_back(p);
         p.due = edge_no + 2; p.d = rd_old; q_b.push_back(p);
      end
      @(posedge CE);
      edge_no++;
      if (wr_ok) begin
         for (int k = 0; k < NM; k++) begin
            if (WM2[k]) m_mem[A2][k*MG +: MG] = I2[k*MG +: MG];
         end
      end
      if (!m_ready) begin
         m_mem[m_clr] = '0;
         m_clr++;
         if (m_clr == DEPTH) m_ready = 1'b1;
      end
      #1;
      $display("t=%0t edge=%0d rd=%0b A1=%h wr=%0b A2=%h WM2=%h | A: V1=%0b O1=%h | B: V1=%0b O1=%h BUSY=%0b",
               $time, edge_no, rd_ok, A1, wr_ok, A2, WM2, v1_a, o1_a, v1_b, o1_b, busy_a);
      check_outs();
   endtask

   task automatic idle();
      CSB1 = 1'b1;
      CSB2 = 1'b1;
      WEB2 = 1'b1;
   endtask

   task automatic apply_reset(input int hold_edges);
      RST = 1'b1;
      q_a.delete();
      q_b.delete();
      eo_a    = '0;
      eo_b    = '0;
      m_clr   = 0;
      m_ready = 1'b0;
      #1;
      check_outs();
      repeat (hold_edges) begin
         @(posedge CE);
         #1;
         check_outs();
      end
      @(negedge CE);
      RST = 1'b0;
   endtask

   task automatic wait_clear();
      int n;
      n = 0;
      while (busy_a && n < 400) begin
         step();
         n++;
      end
      chk("clear_len", DW'(n), DW'(DEPTH));
   endtask

   logic [DW-1:0] ones72;
   logic [DW-1:0] req039_exp;

   initial begin
      edge_no = 0;
      ones72  = '1;
      req039_exp = ones72;
      req039_exp[7:0] = 8'h00;

      // Reset held over several edges, then release.
      apply_reset(3);

      // Write and read to 0x20 during the clear: both must be ignored.
      CSB1 = 1'b0; A1 = 8'h20;
      CSB2 = 1'b0; WEB2 = 1'b0; A2 = 8'h20; I2 = ones72; WM2 = '1;
      step();
      idle();
      begin
         int n;
         n = 1;
         while (busy_a && n < 400) begin
            step();
            n++;
         end
         chk("clear_len_first", DW'(n), DW'(DEPTH));
      end

      // Read 0x20 after the clear: zero.
      CSB1 = 1'b0; A1 = 8'h20;
      step();
      chk("ignored_wr_0x20", o1_a, '0);
      chk("ignored_wr_v1", DW'(v1_a), DW'(1));
      idle();
      step();
      step();

      // Masked write: all ones, then zero into lane 0 only.
      CSB2 = 1'b0; WEB2 = 1'b0; A2 = 8'h10; I2 = ones72; WM2 = 9'h1FF;
      step();
      I2 = '0; WM2 = 9'h001;
      step();
      idle();
      CSB1 = 1'b0; A1 = 8'h10;
      step();
      idle();
      chk("masked_wr_A", o1_a, req039_exp);
      step();
      chk("masked_wr_B", o1_b, req039_exp);
      step();

      // Same-cycle collision at 0x05 (cleared to zero).
      CSB1 = 1'b0; A1 = 8'h05;
      CSB2 = 1'b0; WEB2 = 1'b0; A2 = 8'h05; I2 = 72'h123; WM2 = 9'h1FF;
      step();
      idle();
      chk("collide_bypass_A", o1_a, 72'h123);
      step();
      chk("collide_old_B", o1_b, '0);
      // Read the cycle after the write sees the new word in both.
      CSB1 = 1'b0; A1 = 8'h05;
      step();
      idle();
      step();
      chk("raw_B", o1_b, 72'h123);
      step();

      // Seed 0x01..0x03, then three back-to-back reads.
      for (int i = 1; i <= 3; i++) begin
         CSB2 = 1'b0; WEB2 = 1'b0; A2 = AW'(i); WM2 = '1;
         I2 = {8'($urandom), $urandom, $urandom};
         step();
      end
      idle();
      for (int i = 1; i <= 3; i++) begin
         CSB1 = 1'b0; A1 = AW'(i);
         step();
      end
      idle();
      step();
      step();

      // Random traffic on a narrow address window to provoke collisions.
      for (int i = 0; i < 200; i++) begin
         CSB1 = 1'($urandom_range(0, 3) == 0);
         CSB2 = 1'($urandom_range(0, 2) == 0);
         WEB2 = 1'($urandom_range(0, 3) == 0);
         A1   = AW'($urandom_range(0, 7));
         A2   = AW'($urandom_range(0, 7));
         I2   = {8'($urandom), $urandom, $urandom};
         WM2  = ($urandom_range(0, 5) == 0) ? '0 : NM'($urandom);
         step();
      end
      idle();
      step();
      step();

      // Reset with a read in flight in instance B: no pulse afterwards.
      CSB1 = 1'b0; A1 = 8'h01;
      step();
      idle();
      apply_reset(2);

      // Reset again partway through the clear: full restart.
      for (int i = 0; i < 100; i++) step();
      chk("midclear_busy", DW'(busy_a), DW'(1));
      apply_reset(1);
      wait_clear();

      // Everything cleared again: random full-range traffic.
      for (int i = 0; i < 200; i++) begin
         CSB1 = 1'($urandom_range(0, 2) == 0);
         CSB2 = 1'($urandom_range(0, 2) == 0);
         WEB2 = 1'($urandom_range(0, 3) == 0);
         A1   = (i % 2 == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
         A2   = (i % 2 == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
         I2   = {8'($urandom), $urandom, $urandom};
         WM2  = NM'($urandom);
         step();
      end
      idle();
      step();
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
